// File: rtl/regfile_fwd.sv
// Register file with per-port EX/MEM/WB bypass and load-use stall detection.
// Entry 0 is hardwired to zero; hazard_cnt saturates at 16'hFFFF.
module regfile_fwd #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [NUM_RD-1:0]        re,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD*DATA_W-1:0] rdata,
  input  logic                     ex_wreg,
  input  logic [ADDR_W-1:0]        ex_wd,
  input  logic [DATA_W-1:0]        ex_wdata,
  input  logic                     ex_is_load,
  input  logic                     mem_wreg,
  input  logic [ADDR_W-1:0]        mem_wd,
  input  logic [DATA_W-1:0]        mem_wdata,
  output logic                     stall_req,
  output logic [15:0]              hazard_cnt
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [15:0]       r_hcnt;
  logic [NUM_RD-1:0] w_stall_v;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++)
        r_mem[i] <= '0;
    end else if (we && (waddr != '0)) begin
      r_mem[waddr] <= wdata;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] w_ra;
    logic [DATA_W-1:0] w_rd;
    logic              w_ld;

    assign w_ra = raddr[k*ADDR_W +: ADDR_W];

    // A pending load in EX blocks every younger source for this address.
    always_comb begin
      w_rd = '0;
      w_ld = 1'b0;
      if (!rst && re[k] && (w_ra != '0)) begin
        if (ex_wreg && (ex_wd == w_ra)) begin
          if (ex_is_load)
            w_ld = 1'b1;
          else
            w_rd = ex_wdata;
        end else if (mem_wreg && (mem_wd == w_ra)) begin
          w_rd = mem_wdata;
        end else if (we && (waddr == w_ra)) begin
          w_rd = wdata;
        end else begin
          w_rd = r_mem[w_ra];
        end
      end
    end

    assign rdata[k*DATA_W +: DATA_W] = w_rd;
    assign w_stall_v[k] = w_ld;
  end

  assign stall_req = |w_stall_v;

  always_ff @(posedge clk) begin
    if (rst)
      r_hcnt <= '0;
    else if (stall_req && (r_hcnt != 16'hFFFF))
      r_hcnt <= r_hcnt + 16'd1;
  end

  assign hazard_cnt = r_hcnt;

endmodule

// File: doc/regfile_fwd.md
REGFILE_FWD -- requirements
Module: regfile_fwd

Interface
REQ-001 SHALL provide parameter DATA_W, default 32, register data width.
REQ-002 SHALL provide parameter ADDR_W, default 5, register address width; depth = 2**ADDR_W.
REQ-003 SHALL provide parameter NUM_RD, default 2, number of independent read ports (1..4).
REQ-004 SHALL provide port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL provide port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL provide port we  input  1  write-back write enable.
REQ-007 SHALL provide port waddr  input  ADDR_W  write-back destination register.
REQ-008 SHALL provide port wdata  input  DATA_W  write-back data.
REQ-009 SHALL provide port re  input  NUM_RD  per-port read enable, bit k = port k.
REQ-010 SHALL provide port raddr  input  NUM_RD*ADDR_W  per-port read address, port k at bits [k*ADDR_W +: ADDR_W].
REQ-011 SHALL provide port rdata  output  NUM_RD*DATA_W  per-port read data, port k at bits [k*DATA_W +: DATA_W].
REQ-012 SHALL provide ports ex_wreg/ex_wd/ex_wdata  input  1/ADDR_W/DATA_W  result currently in EX stage.
REQ-013 SHALL provide port ex_is_load  input  1  EX-stage instruction is a load; ex_wdata not yet valid.
REQ-014 SHALL provide ports mem_wreg/mem_wd/mem_wdata  input  1/ADDR_W/DATA_W  result currently in MEM stage.
REQ-015 SHALL provide port stall_req  output  1  load-use hazard; decode must hold one cycle.
REQ-016 SHALL provide port hazard_cnt  output  16  saturating count of cycles with stall_req asserted.

Function
REQ-017 Register array SHALL hold 2**ADDR_W entries of DATA_W bits; entry 0 reads 0 always and is never written.
REQ-018 On rising clk with rst=0, we=1, waddr!=0: entry waddr SHALL take wdata; otherwise array unchanged.
REQ-019 rdata port k SHALL be combinational (zero-cycle latency) from raddr/re/forwarding inputs.
REQ-020 Port k with re[k]=0 SHALL output 0.
REQ-021 Port k with re[k]=1, raddr=0 SHALL output 0 regardless of any forwarding source.
REQ-022 Port k with re[k]=1, raddr!=0 SHALL select, highest priority first: EX (ex_wreg=1, ex_wd=raddr, ex_is_load=0) -> ex_wdata; MEM (mem_wreg=1, mem_wd=raddr) -> mem_wdata; WB (we=1, waddr=raddr) -> wdata; else array entry.
REQ-023 EX match with ex_is_load=1 SHALL NOT fall through to MEM/WB/array; port outputs 0 and hazard is flagged.
REQ-024 stall_req SHALL be 1 when any port k has re[k]=1, raddr!=0, ex_wreg=1, ex_is_load=1, ex_wd=raddr; else 0.
REQ-025 Each read port SHALL resolve forwarding independently; two ports on the same address SHALL return identical data.
REQ-026 hazard_cnt SHALL increment by 1 on each rising clk where stall_req=1 and rst=0; SHALL hold at 16'hFFFF (no wrap).
REQ-027 WB write and WB bypass of the same address in the same cycle SHALL both occur: bypass visible that cycle, array updated next cycle.

Reset
REQ-028 On rising clk with rst=1: all array entries SHALL clear to 0, hazard_cnt SHALL clear to 0, write SHALL be suppressed.
REQ-029 While rst=1: every rdata port SHALL output 0 and stall_req SHALL output 0 regardless of inputs.
REQ-030 Reset asserted mid-operation SHALL discard any same-cycle write; first write accepted is on the first edge with rst=0.

Verification
REQ-031 Write 32'h1234_5678 to r5, next cycle read r5 on port 0 with no forwarding -> rdata[31:0]=32'h1234_5678.
REQ-032 Array r3=32'h1, MEM writes r3=32'h2, EX writes r3=32'h3 (non-load), read r3 on both ports -> both 32'h3; drop EX -> both 32'h2.
REQ-033 EX load to r7, port 1 reads r7 -> stall_req=1, port 1 data 0; after 3 such cycles hazard_cnt=3.
REQ-034 we=1 waddr=0 wdata=32'hFFFF_FFFF, EX/MEM also target r0, read r0 -> rdata=0, stall_req=0, r0 still 0.
REQ-035 Write r9=32'hA5A5_A5A5, assert rst one cycle with we=1 waddr=9 wdata=32'h5A5A_5A5A -> r9 reads 0 after reset, hazard_cnt=0.
REQ-036 Force 65540 consecutive stall cycles -> hazard_cnt=16'hFFFF, no wrap.
